cr16_datapath_controller: RTL and testbench
===========================================

# cr16_datapath_controller

Sequencing controller for the CR16 datapath. It accepts one 16-bit CR16 ALU instruction at a time over a valid/ready handshake, decodes it, and drives the datapath's register-file write enables, operand selects, immediate, and ALU opcode for one or two execute cycles. It also latches the datapath status flags and reports completion or illegal instructions. It sits between the instruction source (fetch unit or bench) and `datapath`.

## Interface
- No parameters. Widths are fixed by CR16: 16-bit words, 16 registers, 5 status flags.
- `I_CLK` in 1: clock. All state updates on the rising edge.
- `I_RESET` in 1: synchronous, active-high reset.
- `I_INSTR` in 16: instruction word. Sampled on the handshake edge.
- `I_INSTR_VALID` in 1: source has an instruction.
- `O_INSTR_READY` out 1: controller is idle and can accept.
- `I_STATUS_FLAGS` in 5: datapath `O_STATUS_FLAGS`.
- `O_REG_WRITE_ENABLE` out 16: one-hot write strobe to the datapath.
- `O_REG_A_SELECT` out 4: A operand register (Rdest).
- `O_REG_B_SELECT` out 4: B operand register (Rsrc).
- `O_IMMEDIATE_SELECT` out 1: B comes from `O_IMMEDIATE`.
- `O_IMMEDIATE` out 16: extended immediate.
- `O_OPCODE` out 4: datapath ALU opcode.
- `O_FLAGS` out 5: latched flags.
- `O_DONE` out 1: one-cycle pulse when an instruction retires.
- `O_ILLEGAL` out 1: one-cycle pulse when an instruction is rejected.

## Operation
- **Encoding:** `op=[15:12]`, `Rd=[11:8]`, `ext=[7:4]`, `Rs=[3:0]`, `imm8=[7:0]`.
- **R-type (`op=0000`), by `ext`:**
  - `0101` ADD, `1001` SUB, `1011` CMP.
  - `0001` AND, `0010` OR, `0011` XOR.
  - `1101` MOV.
  - Any other `ext` is illegal.
- **I-type, by `op`:**
  - `0101` ADDI, `1001` SUBI, `1011` CMPI.
  - `0001` ANDI, `0010` ORI, `0011` XORI.
  - `1101` MOVI, `1111` LUI.
  - Any other `op` is illegal.
- **ALU opcodes (package constants):** ADD=0, SUB=4, AND=6, OR=7, XOR=8.
- **Operands:** A=Rd. B=Rs, or the immediate when `O_IMMEDIATE_SELECT=1`.
- **Result:** result = A op B, written to Rd through `O_REG_WRITE_ENABLE = 1<<Rd`.
- **Immediate extension:**
  - ADDI, SUBI, CMPI: sign-extend `imm8`.
  - ANDI, ORI, XORI, MOVI: zero-extend `imm8`.
  - LUI: `{imm8, 8'h00}`.
- **CMP/CMPI:** execute as SUB with no write enable. Flags only.
- **MOV:** OR with A=Rs, B=Rs, written to Rd.
- **MOVI/LUI:** two micro-ops.
  - EXEC1: XOR Rd,Rd (writes 0 to Rd).
  - EXEC2: ADD Rd, imm.
- **Flag update:** `O_FLAGS` loads `I_STATUS_FLAGS` at the end of the final EXEC cycle for ADD(I), SUB(I), CMP(I), AND(I), OR(I), XOR(I). MOV, MOVI and LUI leave flags unchanged.
- **FSM:**
  - IDLE → DECODE on `I_INSTR_VALID && O_INSTR_READY`; the word is captured into the instruction register.
  - DECODE → EXEC1. On an illegal instruction, DECODE → IDLE with an `O_ILLEGAL` pulse.
  - EXEC1 → EXEC2 for MOVI/LUI; otherwise EXEC1 → IDLE with an `O_DONE` pulse.
  - EXEC2 → IDLE with an `O_DONE` pulse.
- **Outputs outside EXEC states:** all datapath control outputs are 0.

## Timing
- **Reset values:**
  - State IDLE, instruction register 0.
  - All outputs 0, including `O_FLAGS`.
  - `O_INSTR_READY` is 0 during a cycle in which `I_RESET` is high.
- **Ready:** `O_INSTR_READY = (state==IDLE) && !I_RESET`. It is combinational from state.
- **Latency, with the handshake on edge N:**
  - DECODE is cycle N+1; EXEC1 is cycle N+2.
  - The register write and flag latch happen on edge N+3, and `O_DONE` is high in cycle N+2.
  - The next instruction can be accepted in cycle N+3.
  - Throughput is 3 cycles per instruction, or 4 for MOVI/LUI.
- **Illegal instruction:** `O_ILLEGAL` is high in cycle N+1, no datapath activity occurs, and the controller is ready in cycle N+2.
- **Control outputs:** registered, and stable for the whole EXEC cycle.
- **Write gating:** `O_REG_WRITE_ENABLE` is additionally gated by `!I_RESET`, so reset mid-EXEC issues no write. Reset in any state returns to IDLE next cycle and drops the instruction, with no `O_DONE`.
- **Input stability:** `I_INSTR` is ignored outside the handshake. Changing it while busy has no effect.
- **Write targets:** Rd=Rs (e.g. XOR R3,R3) is legal. Rd=0 targets r0 normally; r0 has no special meaning.

## Structure
- **Package `cr16_pkg`:**
  - ALU opcode constants.
  - `op` and `ext` encoding constants.
  - The controller state enum typedef.
  - The flag bit index constants.
- **Sub-module `cr16_decoder`:** combinational. It maps the instruction to {legal, alu_op, use_imm, imm16, writes_rd, sets_flags, two_step}.
- **FSM and registers:** the controller holds the FSM, the instruction register, the output registers, and the flag register.
- **Target size:** about 200–300 lines of RTL total.

## Test plan
- **Reset:** assert `I_RESET` for 2 cycles. All outputs must be 0 and `O_INSTR_READY` must be 0. After release, `O_INSTR_READY` must be 1.
- **ADDI:** `16'h5105` (ADDI R1,5) with valid → in cycle N+2, `O_OPCODE=0`, `O_REG_A_SELECT=1`, `O_IMMEDIATE_SELECT=1`, `O_IMMEDIATE=16'h0005`, `O_REG_WRITE_ENABLE=16'h0002`, `O_DONE=1`. Ready again in N+3.
- **Sign extension and CMPI flags:** `16'h92FF` (SUBI R2,-1) → `O_IMMEDIATE=16'hFFFF`. Then `16'hB303` (CMPI R3,3) → `O_OPCODE=4`, write enable 0, and `O_FLAGS` equals the `I_STATUS_FLAGS` driven during EXEC1 (e.g. 5'b01010).
- **LUI:** `16'hF4AB` (LUI R4,0xAB) → EXEC1 drives XOR (8), A=B=4, write enable `16'h0010`. EXEC2 drives ADD, `O_IMMEDIATE=16'hAB00`, write enable `16'h0010`. `O_DONE` only in EXEC2. `O_FLAGS` unchanged.
- **Illegal instruction:** `16'h0E7E` (R-type, ext `0111`) → `O_ILLEGAL` in N+1, write enable stays 0, ready in N+2.
- **Reset mid-operation:** issue a MOVI, then assert `I_RESET` during EXEC1 → write enable 0 in that cycle, no `O_DONE`, IDLE next cycle. A back-to-back valid held across reset is accepted only after release.

Source files
------------

// File: rtl/cr16_pkg.sv
// cr16_pkg: shared encodings, ALU opcodes, controller states and flag indices for the CR16 controller
package cr16_pkg;
    localparam int FLAG_W = 5;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd6;
    localparam logic [3:0] ALU_OR  = 4'd7;
    localparam logic [3:0] ALU_XOR = 4'd8;
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    // Function codes shared by the R-type ext field and the I-type op field
    localparam logic [3:0] ENC_ADD = 4'b0101;
    localparam logic [3:0] ENC_SUB = 4'b1001;
    localparam logic [3:0] ENC_CMP = 4'b1011;
    localparam logic [3:0] ENC_AND = 4'b0001;
    localparam logic [3:0] ENC_OR  = 4'b0010;
    localparam logic [3:0] ENC_XOR = 4'b0011;
    localparam logic [3:0] ENC_MOV = 4'b1101;
    localparam logic [3:0] ENC_LUI = 4'b1111;
    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC1, ST_EXEC2} state_t;
    typedef enum logic [2:0] {FLAG_C, FLAG_L, FLAG_F, FLAG_Z, FLAG_N} flag_idx_t;
endpackage

// File: rtl/cr16_decoder.sv
// cr16_decoder: combinational decode of one CR16 ALU instruction word
module cr16_decoder
    import cr16_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic        o_legal,
    output logic [3:0]  o_alu_op,
    output logic        o_use_imm,
    output logic [15:0] o_imm16,
    output logic        o_writes_rd,
    output logic        o_sets_flags,
    output logic        o_two_step,
    output logic        o_a_is_rs,
    output logic [3:0]  o_rd,
    output logic [3:0]  o_rs
);
    logic       w_rtype;
    logic [3:0] w_sel;
    logic [7:0] w_imm8;
    assign w_rtype = i_instr[15:12] == OP_RTYPE;
    assign w_sel   = w_rtype ? i_instr[7:4] : i_instr[15:12];
    assign w_imm8  = i_instr[7:0];
    assign o_rd    = i_instr[11:8];
    assign o_rs    = i_instr[3:0];
    always_comb begin
        o_legal      = 1'b0;
        o_alu_op     = ALU_ADD;
        o_writes_rd  = 1'b0;
        o_sets_flags = 1'b0;
        o_two_step   = 1'b0;
        o_a_is_rs    = 1'b0;
        case (w_sel)
            ENC_ADD: {o_legal, o_alu_op, o_writes_rd, o_sets_flags} = {1'b1, ALU_ADD, 2'b11};
            ENC_SUB: {o_legal, o_alu_op, o_writes_rd, o_sets_flags} = {1'b1, ALU_SUB, 2'b11};
            ENC_CMP: {o_legal, o_alu_op, o_writes_rd, o_sets_flags} = {1'b1, ALU_SUB, 2'b01};
            ENC_AND: {o_legal, o_alu_op, o_writes_rd, o_sets_flags} = {1'b1, ALU_AND, 2'b11};
            ENC_OR:  {o_legal, o_alu_op, o_writes_rd, o_sets_flags} = {1'b1, ALU_OR,  2'b11};
            ENC_XOR: {o_legal, o_alu_op, o_writes_rd, o_sets_flags} = {1'b1, ALU_XOR, 2'b11};
            ENC_MOV: begin
                o_legal     = 1'b1;
                o_writes_rd = 1'b1;
                o_alu_op    = w_rtype ? ALU_OR : ALU_ADD;
                o_a_is_rs   = w_rtype;
                o_two_step  = !w_rtype;
            end
            ENC_LUI: begin
                o_legal     = !w_rtype;
                o_writes_rd = !w_rtype;
                o_two_step  = !w_rtype;
            end
            default: o_legal = 1'b0;
        endcase
    end
    assign o_use_imm = o_legal && !w_rtype;
    assign o_imm16   = !o_use_imm ? 16'h0000
                     : w_sel == ENC_LUI ? {w_imm8, 8'h00}
                     : (w_sel inside {ENC_ADD, ENC_SUB, ENC_CMP}) ? {{8{w_imm8[7]}}, w_imm8}
                     : {8'h00, w_imm8};
endmodule

// File: rtl/cr16_datapath_controller.sv
// cr16_datapath_controller: accepts one ALU instruction, sequences its execute micro-ops and latches flags
module cr16_datapath_controller
    import cr16_pkg::*;
(
    input  logic              I_CLK,
    input  logic              I_RESET,
    input  logic [15:0]       I_INSTR,
    input  logic              I_INSTR_VALID,
    output logic              O_INSTR_READY,
    input  logic [FLAG_W-1:0] I_STATUS_FLAGS,
    output logic [15:0]       O_REG_WRITE_ENABLE,
    output logic [3:0]        O_REG_A_SELECT,
    output logic [3:0]        O_REG_B_SELECT,
    output logic              O_IMMEDIATE_SELECT,
    output logic [15:0]       O_IMMEDIATE,
    output logic [3:0]        O_OPCODE,
    output logic [FLAG_W-1:0] O_FLAGS,
    output logic              O_DONE,
    output logic              O_ILLEGAL
);
    state_t            r_state, w_next;
    logic [15:0]       r_instr;
    logic [15:0]       r_we, w_we;
    logic [3:0]        r_a, w_a, r_b, w_b, r_op, w_op;
    logic              r_isel, w_isel, r_done, w_done;
    logic [15:0]       r_imm, w_imm;
    logic [FLAG_W-1:0] r_flags;
    logic              w_legal, w_use_imm, w_writes_rd, w_sets_flags, w_two_step, w_a_is_rs;
    logic [3:0]        w_alu_op, w_rd, w_rs;
    logic [15:0]       w_imm16;
    logic              w_accept, w_to_e1, w_to_e2;
    cr16_decoder u_dec (
        .i_instr      (r_instr),
        .o_legal      (w_legal),
        .o_alu_op     (w_alu_op),
        .o_use_imm    (w_use_imm),
        .o_imm16      (w_imm16),
        .o_writes_rd  (w_writes_rd),
        .o_sets_flags (w_sets_flags),
        .o_two_step   (w_two_step),
        .o_a_is_rs    (w_a_is_rs),
        .o_rd         (w_rd),
        .o_rs         (w_rs)
    );
    assign O_INSTR_READY = (r_state == ST_IDLE) && !I_RESET;
    assign w_accept      = I_INSTR_VALID && O_INSTR_READY;
    assign w_to_e1       = (r_state == ST_DECODE) && w_legal;
    assign w_to_e2       = (r_state == ST_EXEC1) && w_two_step;
    always_comb begin
        w_next = r_state == ST_IDLE   ? (w_accept ? ST_DECODE : ST_IDLE)
               : r_state == ST_DECODE ? (w_legal ? ST_EXEC1 : ST_IDLE)
               : r_state == ST_EXEC1  ? (w_two_step ? ST_EXEC2 : ST_IDLE)
               : ST_IDLE;
    end
    // Control outputs are computed one cycle ahead so they are registered for the whole EXEC cycle
    always_comb begin
        w_op   = ALU_ADD;
        w_a    = 4'd0;
        w_b    = 4'd0;
        w_isel = 1'b0;
        w_imm  = 16'h0000;
        w_we   = 16'h0000;
        w_done = 1'b0;
        if (w_to_e1) begin
            w_op   = w_two_step ? ALU_XOR : w_alu_op;
            w_a    = w_a_is_rs ? w_rs : w_rd;
            w_b    = w_two_step ? w_rd : (w_use_imm ? 4'd0 : w_rs);
            w_isel = w_use_imm && !w_two_step;
            w_imm  = (w_use_imm && !w_two_step) ? w_imm16 : 16'h0000;
            w_we   = w_writes_rd ? 16'd1 << w_rd : 16'h0000;
            w_done = !w_two_step;
        end else if (w_to_e2) begin
            w_op   = ALU_ADD;
            w_a    = w_rd;
            w_isel = 1'b1;
            w_imm  = w_imm16;
            w_we   = 16'd1 << w_rd;
            w_done = 1'b1;
        end
    end
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state <= ST_IDLE;
            r_instr <= 16'h0000;
            r_op    <= 4'd0;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_isel  <= 1'b0;
            r_imm   <= 16'h0000;
            r_we    <= 16'h0000;
            r_done  <= 1'b0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_isel  <= w_isel;
            r_imm   <= w_imm;
            r_we    <= w_we;
            r_done  <= w_done;
            if (w_accept)
                r_instr <= I_INSTR;
            if (r_state == ST_EXEC1 && !w_two_step && w_sets_flags)
                r_flags <= I_STATUS_FLAGS;
        end
    end
    assign O_REG_WRITE_ENABLE = r_we & {16{!I_RESET}};
    assign O_REG_A_SELECT     = r_a;
    assign O_REG_B_SELECT     = r_b;
    assign O_IMMEDIATE_SELECT = r_isel;
    assign O_IMMEDIATE        = r_imm;
    assign O_OPCODE           = r_op;
    assign O_FLAGS            = r_flags;
    assign O_DONE             = r_done && !I_RESET;
    assign O_ILLEGAL          = (r_state == ST_DECODE) && !w_legal && !I_RESET;
endmodule

// File: tb/tb_cr16_datapath_controller.sv
// tb_cr16_datapath_controller: table, hand-written and random checks against a mnemonic-level model
module tb_cr16_datapath_controller;
    logic        I_CLK = 1'b0, I_RESET = 1'b1, I_INSTR_VALID = 1'b0;
    logic [15:0] I_INSTR = 16'h0000;
    logic [4:0]  I_STATUS_FLAGS = 5'd0;
    logic        O_INSTR_READY, O_IMMEDIATE_SELECT, O_DONE, O_ILLEGAL;
    logic [15:0] O_REG_WRITE_ENABLE, O_IMMEDIATE;
    logic [3:0]  O_REG_A_SELECT, O_REG_B_SELECT, O_OPCODE;
    logic [4:0]  O_FLAGS;
    int          n_vec = 0, n_err = 0;
    logic [4:0]  m_flags = 5'd0;

    cr16_datapath_controller dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_INSTR(I_INSTR), .I_INSTR_VALID(I_INSTR_VALID),
        .O_INSTR_READY(O_INSTR_READY), .I_STATUS_FLAGS(I_STATUS_FLAGS),
        .O_REG_WRITE_ENABLE(O_REG_WRITE_ENABLE), .O_REG_A_SELECT(O_REG_A_SELECT),
        .O_REG_B_SELECT(O_REG_B_SELECT), .O_IMMEDIATE_SELECT(O_IMMEDIATE_SELECT),
        .O_IMMEDIATE(O_IMMEDIATE), .O_OPCODE(O_OPCODE), .O_FLAGS(O_FLAGS),
        .O_DONE(O_DONE), .O_ILLEGAL(O_ILLEGAL)
    );

    always #5 I_CLK = ~I_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] instr;
        logic        ill, two;
        logic [3:0]  op, a, b;
        logic        is;
        logic [15:0] imm, we, imm2;
        logic        fl;
    } vec_t;

    function automatic vec_t mk(logic [15:0] instr, logic ill, logic two, logic [3:0] op, logic [3:0] a,
                                logic [3:0] b, logic is, logic [15:0] imm, logic [15:0] we,
                                logic [15:0] imm2, logic fl);
        vec_t v;
        v.instr = instr; v.ill = ill; v.two = two; v.op = op; v.a = a; v.b = b;
        v.is = is; v.imm = imm; v.we = we; v.imm2 = imm2; v.fl = fl;
        return v;
    endfunction

    // Expected behaviour derived from the mnemonic of the instruction
    function automatic vec_t model(logic [15:0] w);
        logic [3:0]  rd = w[11:8], rs = w[3:0];
        logic [7:0]  i8 = w[7:0];
        logic        rt = (w[15:12] == 4'd0);
        logic [3:0]  f  = rt ? w[7:4] : w[15:12];
        int          alu;
        logic [15:0] imm, we;
        case (f)
            4'd5:        alu = 0;
            4'd9, 4'd11: alu = 4;
            4'd1:        alu = 6;
            4'd2:        alu = 7;
            4'd3:        alu = 8;
            4'd13:       alu = rt ? 7 : 0;
            4'd15:       alu = rt ? -1 : 0;
            default:     alu = -1;
        endcase
        if (alu < 0) return mk(w, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (f == 4'd15) imm = {i8, 8'h00};
        else if (f == 4'd5 || f == 4'd9 || f == 4'd11) imm = 16'(signed'(i8));
        else imm = {8'h00, i8};
        we = (f == 4'd11) ? 16'h0000 : 16'h0001 << rd;
        if (!rt && (f == 4'd13 || f == 4'd15)) return mk(w, 0, 1, 8, rd, rd, 0, 0, we, imm, 0);
        if (rt && f == 4'd13) return mk(w, 0, 0, 7, rs, rs, 0, 0, we, 0, 0);
        return mk(w, 0, 0, 4'(alu), rd, rt ? rs : 4'd0, !rt, rt ? 16'h0000 : imm, we, 0, 1);
    endfunction

    function automatic logic [63:0] pk(logic [3:0] op, logic [3:0] a, logic [3:0] b, logic is,
                                       logic [15:0] imm, logic [15:0] we, logic done, logic ill, logic rdy);
        return {16'h0000, op, a, b, is, imm, we, done, ill, rdy};
    endfunction

    function automatic logic [63:0] snap();
        return pk(O_OPCODE, O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE_SELECT, O_IMMEDIATE,
                  O_REG_WRITE_ENABLE, O_DONE, O_ILLEGAL, O_INSTR_READY);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 8 && O_INSTR_READY !== 1'b1; k++) step();
        check("ready_wait", 64'(O_INSTR_READY), 64'd1);
    endtask

    task automatic apply(input vec_t v);
        logic [4:0] fl;
        wait_ready();
        I_INSTR = v.instr;
        I_INSTR_VALID = 1'b1;
        step();
        I_INSTR_VALID = 1'b0;
        I_INSTR = 16'($urandom);
        I_STATUS_FLAGS = 5'($urandom);
        check($sformatf("decode %h", v.instr), snap(), pk(0, 0, 0, 0, 0, 0, 0, v.ill, 0));
        step();
        if (v.ill) begin
            check($sformatf("after_illegal %h", v.instr), snap(), pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
            check($sformatf("flags_illegal %h", v.instr), 64'(O_FLAGS), 64'(m_flags));
            return;
        end
        fl = 5'($urandom);
        I_STATUS_FLAGS = fl;
        check($sformatf("exec1 %h", v.instr), snap(), pk(v.op, v.a, v.b, v.is, v.imm, v.we, !v.two, 0, 0));
        if (v.two) begin
            step();
            fl = 5'($urandom);
            I_STATUS_FLAGS = fl;
            check($sformatf("exec2 %h", v.instr), snap(), pk(0, v.a, 0, 1, v.imm2, v.we, 1, 0, 0));
        end
        step();
        if (v.fl) m_flags = fl;
        I_STATUS_FLAGS = 5'($urandom);
        check($sformatf("retire %h", v.instr), snap(), pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        check($sformatf("flags %h", v.instr), 64'(O_FLAGS), 64'(m_flags));
    endtask

    initial begin
        vec_t       tbl[$];
        logic [15:0] w;
        logic [4:0]  fl;
        tbl.push_back(mk(16'h5105, 0, 0, 0, 1, 0, 1, 16'h0005, 16'h0002, 0, 1));
        tbl.push_back(mk(16'h92FF, 0, 0, 4, 2, 0, 1, 16'hFFFF, 16'h0004, 0, 1));
        tbl.push_back(mk(16'hB303, 0, 0, 4, 3, 0, 1, 16'h0003, 16'h0000, 0, 1));
        tbl.push_back(mk(16'h5080, 0, 0, 0, 0, 0, 1, 16'hFF80, 16'h0001, 0, 1));
        tbl.push_back(mk(16'h1780, 0, 0, 6, 7, 0, 1, 16'h0080, 16'h0080, 0, 1));
        tbl.push_back(mk(16'h2AF0, 0, 0, 7, 10, 0, 1, 16'h00F0, 16'h0400, 0, 1));
        tbl.push_back(mk(16'h3C81, 0, 0, 8, 12, 0, 1, 16'h0081, 16'h1000, 0, 1));
        tbl.push_back(mk(16'h0E7E, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(16'h0352, 0, 0, 0, 3, 2, 0, 0, 16'h0008, 0, 1));
        tbl.push_back(mk(16'h0093, 0, 0, 4, 0, 3, 0, 0, 16'h0001, 0, 1));
        tbl.push_back(mk(16'h05BF, 0, 0, 4, 5, 15, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(16'h0613, 0, 0, 6, 6, 3, 0, 0, 16'h0040, 0, 1));
        tbl.push_back(mk(16'h0F2F, 0, 0, 7, 15, 15, 0, 0, 16'h8000, 0, 1));
        tbl.push_back(mk(16'h0333, 0, 0, 8, 3, 3, 0, 0, 16'h0008, 0, 1));
        tbl.push_back(mk(16'h04D9, 0, 0, 7, 9, 9, 0, 0, 16'h0010, 0, 0));
        tbl.push_back(mk(16'hF4AB, 0, 1, 8, 4, 4, 0, 0, 16'h0010, 16'hAB00, 0));
        tbl.push_back(mk(16'hD1FE, 0, 1, 8, 1, 1, 0, 0, 16'h0002, 16'h00FE, 0));
        tbl.push_back(mk(16'h4123, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(16'h00F0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(16'h8000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        I_RESET = 1'b1;
        step();
        check("reset_c1", snap(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        check("reset_c2", snap(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("reset_flags", 64'(O_FLAGS), 64'd0);
        I_RESET = 1'b0;
        #1;
        check("ready_after_reset", 64'(O_INSTR_READY), 64'd1);

        foreach (tbl[i]) apply(tbl[i]);

        // Reset during EXEC1 of a MOVI with another instruction held valid
        wait_ready();
        I_INSTR = 16'hD733;
        I_INSTR_VALID = 1'b1;
        step();
        I_INSTR = 16'h5201;
        step();
        I_RESET = 1'b1;
        #1;
        check("rst_mid_we", 64'(O_REG_WRITE_ENABLE), 64'd0);
        check("rst_mid_done_ready", {62'd0, O_DONE, O_INSTR_READY}, 64'd0);
        step();
        m_flags = 5'd0;
        check("rst_held", snap(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("rst_held_flags", 64'(O_FLAGS), 64'(m_flags));
        I_RESET = 1'b0;
        #1;
        check("rst_release_ready", 64'(O_INSTR_READY), 64'd1);
        step();
        I_INSTR_VALID = 1'b0;
        check("rst_next_decode", snap(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        fl = 5'b01010;
        I_STATUS_FLAGS = fl;
        check("rst_next_exec1", snap(), pk(0, 2, 0, 1, 16'h0001, 16'h0004, 1, 0, 0));
        step();
        m_flags = fl;
        check("rst_next_retire", snap(), pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        check("rst_next_flags", 64'(O_FLAGS), 64'(m_flags));

        for (int i = 0; i < 150; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w[15:12] = 4'd0;
            apply(model(w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
